// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU and external loader) in front of a single-port memory.
// Round-robin with an EXT burst-lock hint and a CPU starvation override; one access per grant cycle.
module mem_arbiter #(
    parameter int unsigned AW       = 64,
    parameter int unsigned DW       = 64,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GNT_CPU = 2'b01;
    localparam logic [1:0] GNT_EXT = 2'b10;

    localparam int unsigned         WAIT_W     = 4;
    localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0]   WAIT_SAT   = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_ext;
    logic              lock_flag;
    logic [WAIT_W-1:0] cpu_wait;
    logic              cpu_elig;
    logic              ext_elig;
    logic              starved;
    logic              pick_cpu;
    logic              pick_ext;

    // A port whose ack is high is in its completion cycle and must not be re-served yet.
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign ext_elig = ext_req & ~ext_ack;
    assign starved  = (cpu_wait >= WAIT_LIMIT);
    assign owner    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and arbitration decision; grants always fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        pick_cpu  = 1'b0;
        pick_ext  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig && ext_elig) begin
                    pick_cpu = starved || (last_ext && !lock_flag);
                    pick_ext = !pick_cpu;
                end else begin
                    pick_cpu = cpu_elig;
                    pick_ext = ext_elig;
                end
                if (pick_cpu) begin
                    state_nxt = GNT_CPU;
                end else if (pick_ext) begin
                    state_nxt = GNT_EXT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port follows the granted requester straight from state, so reset kills the strobe at once.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            GNT_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            GNT_EXT: begin
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    // Acks, read data capture, round-robin pointer, lock hint and CPU starvation counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            last_ext  <= 1'b1;
            lock_flag <= 1'b0;
            cpu_wait  <= '0;
        end else begin
            cpu_ack <= (state == GNT_CPU);
            ext_ack <= (state == GNT_EXT);
            if ((state == GNT_CPU) && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if ((state == GNT_EXT) && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
            if (pick_cpu) begin
                last_ext  <= 1'b0;
                lock_flag <= 1'b0;
                cpu_wait  <= '0;
            end else begin
                if (pick_ext) begin
                    last_ext  <= 1'b1;
                    lock_flag <= ext_lock;
                end
                if ((state == IDLE) && cpu_elig && (cpu_wait != WAIT_SAT)) begin
                    cpu_wait <= cpu_wait + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with a read-data scoreboard
// filled when requests are issued and drained on each ack.
module tb_mem_arbiter;

    localparam int unsigned AW       = 64;
    localparam int unsigned DW       = 64;
    localparam int unsigned MAX_WAIT = 8;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          cpu_req   = 1'b0;
    logic          cpu_we    = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req   = 1'b0;
    logic          ext_we    = 1'b0;
    logic          ext_lock  = 1'b0;
    logic [AW-1:0] ext_addr  = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_ack;
    logic [DW-1:0] ext_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;

    int checks   = 0;
    int failures = 0;
    int mem_we_cycles = 0;

    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] ext_q[$];
    logic [DW-1:0] cpu_last = '0;
    logic [DW-1:0] ext_last = '0;

    logic [DW-1:0] ram [64] = '{1: 64'h20030226, default: '0};

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_lock  (ext_lock),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard drain: every ack must match the oldest outstanding expectation of its port.
    always @(negedge clk) begin
        if (mem_we) mem_we_cycles++;
        if (cpu_ack) begin
            if (cpu_q.size() == 0) check("cpu_ack_unexpected", 64'd1, 64'd0);
            else check("cpu_rdata_sb", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
        end
        if (ext_ack) begin
            if (ext_q.size() == 0) check("ext_ack_unexpected", 64'd1, 64'd0);
            else check("ext_rdata_sb", 64'(ext_rdata), 64'(ext_q.pop_front()));
        end
        if (cpu_ack || ext_ack) check("ack_exclusive", 64'(cpu_ack & ext_ack), 64'd0);
        if (owner == 2'b11) check("owner_encoding", 64'(owner), 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writes leave rdata unchanged, reads replace it.
    task automatic push_cpu(input logic we, input logic [DW-1:0] val);
        if (!we) cpu_last = val;
        cpu_q.push_back(cpu_last);
    endtask

    task automatic push_ext(input logic we, input logic [DW-1:0] val);
        if (!we) ext_last = val;
        ext_q.push_back(ext_last);
    endtask

    task automatic wait_ack(input bit is_cpu);
        int n = 0;
        while (((is_cpu && !cpu_ack) || (!is_cpu && !ext_ack)) && n < 20) begin
            step();
            n++;
        end
        if (is_cpu) check("cpu_ack_timeout", 64'(cpu_ack), 64'd1);
        else        check("ext_ack_timeout", 64'(ext_ack), 64'd1);
    endtask

    // EXT streams with lock while CPU only competes outside EXT ack cycles, so every IDLE is a tie.
    task automatic lock_phase(output int n_ext);
        bit done    = 1'b0;
        bit granted = 1'b0;
        cpu_we = 1'b0; cpu_addr = 64'd4;
        ext_we = 1'b0; ext_addr = 64'd20;
        for (int k = 0; k < int'(MAX_WAIT) + 1; k++) push_ext(1'b0, 64'h3E8);
        push_cpu(1'b0, 64'h20030226);
        ext_lock = 1'b1;
        ext_req  = 1'b1;
        cpu_req  = 1'b0;
        step();
        n_ext = (owner == 2'b10) ? 1 : 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!granted) cpu_req = !ext_ack;
            step();
            if (owner == 2'b10) n_ext++;
            if (owner == 2'b01) begin
                granted = 1'b1;
                ext_req = 1'b0;
            end
            if (cpu_ack) begin
                cpu_req = 1'b0;
                done    = 1'b1;
            end
        end
        check("lock_phase_done", 64'(done), 64'd1);
        ext_lock = 1'b0;
        ext_req  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] tie_seq [8];
        int         we_base;
        int         n_ext;
        tie_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

        // Reset values
        repeat (3) step();
        check("rst_owner",     64'(owner),     64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_cpu_ack",   64'(cpu_ack),   64'd0);
        check("rst_ext_ack",   64'(ext_ack),   64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_ext_rdata", 64'(ext_rdata), 64'd0);
        reset = 1'b1;
        step();

        // Single CPU read with two-cycle latency
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd4;
        push_cpu(1'b0, 64'h20030226);
        step();
        check("rd_owner_cpu", 64'(owner),    64'd1);
        check("rd_mem_addr",  64'(mem_addr), 64'd4);
        check("rd_mem_we",    64'(mem_we),   64'd0);
        step();
        check("rd_cpu_ack",   64'(cpu_ack),   64'd1);
        check("rd_cpu_rdata", 64'(cpu_rdata), 64'h20030226);
        check("rd_owner_idle", 64'(owner),    64'd0);
        cpu_req = 1'b0;
        step();
        check("rd_ack_pulse", 64'(cpu_ack), 64'd0);

        // EXT write followed by CPU read of the same word
        we_base = mem_we_cycles;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 64'd20; ext_wdata = 64'h3E8;
        push_ext(1'b1, '0);
        step();
        check("wr_owner_ext",  64'(owner),     64'd2);
        check("wr_mem_we",     64'(mem_we),    64'd1);
        check("wr_mem_addr",   64'(mem_addr),  64'd20);
        check("wr_mem_wdata",  64'(mem_wdata), 64'h3E8);
        step();
        check("wr_ext_ack",    64'(ext_ack), 64'd1);
        check("wr_mem_we_off", 64'(mem_we),  64'd0);
        ext_req = 1'b0; ext_we = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd20;
        push_cpu(1'b0, 64'h3E8);
        wait_ack(1'b1);
        cpu_req = 1'b0;
        step();
        check("wr_we_cycles", 64'(mem_we_cycles - we_base), 64'd1);

        // Tie straight out of reset: CPU first, then strict alternation
        reset = 1'b0;
        cpu_last = '0; ext_last = '0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd4;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'd20;
        push_cpu(1'b0, 64'h20030226); push_cpu(1'b0, 64'h20030226);
        push_ext(1'b0, 64'h3E8);      push_ext(1'b0, 64'h3E8);
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tie_owner_%0d", i), 64'(owner), 64'(tie_seq[i]));
            if (i == 6) cpu_req = 1'b0;
            step();
        end
        ext_req = 1'b0;
        step();

        // Lock holds EXT until the CPU has waited MAX_WAIT ties; repeated to prove the counter cleared
        lock_phase(n_ext);
        check("lock_ext_grants_1", 64'(n_ext), 64'(MAX_WAIT + 1));
        lock_phase(n_ext);
        check("lock_ext_grants_2", 64'(n_ext), 64'(MAX_WAIT + 1));

        // Reset in the middle of an EXT write grant
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 64'd24; ext_wdata = 64'hDEADBEEF;
        step();
        check("midrst_owner_pre", 64'(owner),  64'd2);
        check("midrst_we_pre",    64'(mem_we), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_mem_we",    64'(mem_we),    64'd0);
        check("midrst_owner",     64'(owner),     64'd0);
        check("midrst_mem_addr",  64'(mem_addr),  64'd0);
        check("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("midrst_ext_ack",   64'(ext_ack),   64'd0);
        check("midrst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("midrst_ext_rdata", 64'(ext_rdata), 64'd0);
        ext_req = 1'b0; ext_we = 1'b0;
        cpu_last = '0; ext_last = '0;
        step();
        check("midrst_no_write", 64'(ram[6]),  64'd0);
        check("midrst_no_ack",   64'(ext_ack), 64'd0);
        reset = 1'b1;
        step();
        check("midrst_no_ack_post", 64'(ext_ack), 64'd0);

        // CPU write keeps the previous rdata; readback returns the written word
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'd28; cpu_wdata = 64'h123456789ABCDEF0;
        push_cpu(1'b1, '0);
        wait_ack(1'b1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();

        // Request held through ack and then dropped: no second grant
        cpu_req = 1'b1; cpu_addr = 64'd28;
        push_cpu(1'b0, 64'h123456789ABCDEF0);
        step();
        check("hold_owner_g1", 64'(owner),   64'd1);
        step();
        check("hold_ack_1",    64'(cpu_ack), 64'd1);
        step();
        check("hold_no_regrant", 64'(owner), 64'd0);
        cpu_req = 1'b0;
        step();
        check("hold_dropped_idle", 64'(owner), 64'd0);

        // Request held past the ack cycle: exactly one new grant after the idle cycle
        cpu_req = 1'b1; cpu_addr = 64'd4;
        push_cpu(1'b0, 64'h20030226); push_cpu(1'b0, 64'h20030226);
        step();
        check("rehold_owner_g1", 64'(owner),   64'd1);
        step();
        check("rehold_ack_1",    64'(cpu_ack), 64'd1);
        check("rehold_idle_ack", 64'(owner),   64'd0);
        step();
        check("rehold_idle_2",   64'(owner),   64'd0);
        step();
        check("rehold_owner_g2", 64'(owner),   64'd1);
        step();
        check("rehold_ack_2",    64'(cpu_ack), 64'd1);
        cpu_req = 1'b0;
        step();
        step();

        check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        check("ext_q_drained", 64'(ext_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
